// File: rtl/spi_responder.sv
// spi_responder: SPI slave front-end oversampled in the system clock domain.
// SCK, SS_n and MOSI are synchronised and edge-detected; no logic runs on SCK.
// Ports:
//   i2c_wb_clk_i / i2c_wb_rst_i : system clock, async active-high reset
//   sck_i, ss_n_i, mosi_i       : SPI pins from the master (asynchronous)
//   miso_o, miso_oe_o           : slave data out and its output enable
//   rx_data_o, rx_valid_o       : last received word and one-cycle update strobe
//   tx_data_i, tx_valid_i,
//   tx_ready_o                  : ready/valid holding register for the next TX word
//   tx_underrun_o               : one-cycle strobe, DEFAULT_TX loaded instead of a word
//   busy_o                      : frame active
module spi_responder #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(8'hFF)
) (
  input  logic                  i2c_wb_clk_i,
  input  logic                  i2c_wb_rst_i,
  input  logic                  sck_i,
  input  logic                  ss_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int unsigned           CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  // Synchroniser chains; flush_q marks when reset values have drained out.
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic                   sck_prev_q, sck_prev_d;

  logic sck_s, ss_n_s, mosi_s, flushed;
  logic lead_edge, trail_edge, sample_edge, shift_edge, word_done;

  state_t                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    miso_q, miso_d;
  logic                    miso_oe_q, miso_oe_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_underrun_q, tx_underrun_d;
  logic                    busy_q, busy_d;
  logic                    load_req;

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign ss_n_s  = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign flushed = flush_q[SYNC_STAGES-1];

  assign lead_edge   = (sck_prev_q == CPOL) && (sck_s != CPOL);
  assign trail_edge  = (sck_prev_q != CPOL) && (sck_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign word_done   = (bit_cnt_q == CNT_FULL);

  // Synchroniser next-state
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
    sck_prev_d  = sck_s;
  end

  // Frame FSM, shift datapath and holding register
  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    busy_d        = busy_q;
    load_req      = 1'b0;

    // A frame may only start after a genuine (post-reset) high on ss_n,
    // so a frame already running across reset is ignored.
    if (flushed && ss_n_s) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !ss_n_s) begin
          state_d    = ST_ACTIVE;
          busy_d     = 1'b1;
          miso_oe_d  = 1'b1;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          load_req   = !CPHA;
        end
      end

      ST_ACTIVE: begin
        if (word_done) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
        end

        if (ss_n_s) begin
          // Frame end wins over any coincident SCK edge
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          miso_oe_d  = 1'b0;
          miso_d     = 1'b0;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else if (word_done) begin
          load_req = !CPHA;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          bit_cnt_d  = CNT_W'(bit_cnt_q + 1'b1);
        end else if (shift_edge) begin
          // At count 0 the word is freshly loaded (CPHA=0) or must load now
          // (CPHA=1); otherwise advance to the next bit. Rotation keeps the
          // register contents intact; only the bit presented on miso matters.
          if (bit_cnt_q == '0) begin
            load_req = CPHA;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], tx_shift_q[DATA_WIDTH-1]};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end
      end
    endcase

    // Load uses the holding register contents from before any same-cycle accept
    if (load_req) begin
      if (!tx_ready_q) begin
        tx_shift_d = hold_q;
        miso_d     = hold_q[DATA_WIDTH-1];
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d    = DEFAULT_TX;
        miso_d        = DEFAULT_TX[DATA_WIDTH-1];
        tx_underrun_d = 1'b1;
      end
    end

    if (tx_valid_i && tx_ready_q) begin
      hold_d     = tx_data_i;
      tx_ready_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge i2c_wb_clk_i or posedge i2c_wb_rst_i) begin
    if (i2c_wb_rst_i) begin
      sck_sync_q    <= {SYNC_STAGES{CPOL}};
      ss_sync_q     <= '1;
      mosi_sync_q   <= '0;
      flush_q       <= '0;
      sck_prev_q    <= CPOL;
      state_q       <= ST_IDLE;
      armed_q       <= 1'b0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      tx_ready_q    <= 1'b1;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      flush_q       <= flush_d;
      sck_prev_q    <= sck_prev_d;
      state_q       <= state_d;
      armed_q       <= armed_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      busy_q        <= busy_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = miso_oe_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = tx_ready_q;
  assign tx_underrun_o = tx_underrun_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a mode-0 instance and a mode-3
// (CPOL=1, CPHA=1) instance share SCK/MOSI/tx_data with separate selects.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, mosi, ss0_n, ss3_n;
  logic [7:0] tx_data;
  logic       tx_valid0, tx_valid3;

  logic       miso0, oe0, rx_valid0, ready0, und0, busy0;
  logic [7:0] rx_data0;
  logic       miso3, oe3, rx_valid3, ready3, und3, busy3;
  logic [7:0] rx_data3;

  always #5 clk = ~clk;

  spi_responder #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2),
                  .DEFAULT_TX(8'hFF)) u_m0 (
    .i2c_wb_clk_i(clk), .i2c_wb_rst_i(rst),
    .sck_i(sck), .ss_n_i(ss0_n), .mosi_i(mosi),
    .miso_o(miso0), .miso_oe_o(oe0),
    .rx_data_o(rx_data0), .rx_valid_o(rx_valid0),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid0), .tx_ready_o(ready0),
    .tx_underrun_o(und0), .busy_o(busy0));

  spi_responder #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2),
                  .DEFAULT_TX(8'hFF)) u_m3 (
    .i2c_wb_clk_i(clk), .i2c_wb_rst_i(rst),
    .sck_i(sck), .ss_n_i(ss3_n), .mosi_i(mosi),
    .miso_o(miso3), .miso_oe_o(oe3),
    .rx_data_o(rx_data3), .rx_valid_o(rx_valid3),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid3), .tx_ready_o(ready3),
    .tx_underrun_o(und3), .busy_o(busy3));

  int tests = 0;
  int fails = 0;
  int rxc0 = 0, rxc3 = 0, undc0 = 0, undc3 = 0;
  int und_snap = 0;
  logic [7:0] rx_last0, rx_prev0, rx_last3;

  // Strobe counters and captured RX words
  always @(posedge clk) begin
    if (rx_valid0) begin
      rx_prev0 = rx_last0;
      rx_last0 = rx_data0;
      rxc0++;
    end
    if (rx_valid3) begin
      rx_last3 = rx_data3;
      rxc3++;
    end
    if (und0) undc0++;
    if (und3) undc3++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Half SCK period = 8 system clocks
  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic sel(input bit m3, input logic v);
    if (m3) ss3_n = v;
    else    ss0_n = v;
  endtask

  task automatic frame_begin(input bit m3);
    @(negedge clk);
    sel(m3, 1'b0);
    half(); half();
  endtask

  task automatic frame_end(input bit m3);
    half(); half();
    sel(m3, 1'b1);
    half(); half();
  endtask

  // Master shifts nbits of mo MSB first; mi collects MISO at the master's sample edge.
  // und_snap records the underrun count when the final bit is sampled.
  task automatic xfer(input bit m3, input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!m3) begin
        mosi = mo[7-i];
        half();
        sck = 1'b1;
        mi = {mi[6:0], miso0};
        if (i == nbits - 1) und_snap = undc0;
        half();
        sck = 1'b0;
      end else begin
        sck  = 1'b0;
        mosi = mo[7-i];
        half();
        sck = 1'b1;
        mi = {mi[6:0], miso3};
        if (i == nbits - 1) und_snap = undc3;
        half();
      end
    end
  endtask

  task automatic push(input bit m3, input logic [7:0] d);
    @(negedge clk);
    check("ready_before_push", 32'(m3 ? ready3 : ready0), 32'd1);
    tx_data = d;
    if (m3) tx_valid3 = 1'b1;
    else    tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
    check("ready_after_push", 32'(m3 ? ready3 : ready0), 32'd0);
  endtask

  logic [7:0]  mi, mi1, mi2;
  logic [12:0] rst_exp;
  int          r0, u0, u3;

  initial begin
    rst       = 1'b1;
    sck       = 1'b0;
    mosi      = 1'b0;
    ss0_n     = 1'b1;
    ss3_n     = 1'b1;
    tx_data   = '0;
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
    rst_exp   = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({miso0, oe0, rx_data0, rx_valid0, ready0, und0, busy0}),
          32'(rst_exp));
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Mode 0 single word
    push(1'b0, 8'hA5);
    r0 = rxc0; u0 = undc0;
    frame_begin(1'b0);
    check("busy_in_frame", 32'(busy0), 32'd1);
    check("oe_in_frame", 32'(oe0), 32'd1);
    xfer(1'b0, 8'h3C, 8, mi);
    frame_end(1'b0);
    check("m0_master_rx", 32'(mi), 32'hA5);
    check("m0_rx_pulses", 32'(rxc0 - r0), 32'd1);
    check("m0_rx_data", 32'(rx_last0), 32'h3C);
    check("m0_ready_back", 32'(ready0), 32'd1);
    check("m0_no_underrun", 32'(und_snap - u0), 32'd0);

    // Back-to-back words, second TX word written mid-frame
    push(1'b0, 8'h11);
    r0 = rxc0; u0 = undc0;
    frame_begin(1'b0);
    push(1'b0, 8'h22);
    xfer(1'b0, 8'h01, 8, mi1);
    xfer(1'b0, 8'h02, 8, mi2);
    frame_end(1'b0);
    check("b2b_miso_w1", 32'(mi1), 32'h11);
    check("b2b_miso_w2", 32'(mi2), 32'h22);
    check("b2b_rx_pulses", 32'(rxc0 - r0), 32'd2);
    check("b2b_rx_w1", 32'(rx_prev0), 32'h01);
    check("b2b_rx_w2", 32'(rx_last0), 32'h02);
    check("b2b_no_underrun", 32'(und_snap - u0), 32'd0);

    // Underrun: empty holding register
    u0 = undc0;
    frame_begin(1'b0);
    xfer(1'b0, 8'h55, 8, mi);
    frame_end(1'b0);
    check("und_miso_default", 32'(mi), 32'hFF);
    check("und_pulse_once", 32'(und_snap - u0), 32'd1);
    check("und_rx_data", 32'(rx_last0), 32'h55);
    check("und_end_of_word_load", 32'(undc0 - u0), 32'd2);

    // Abort after 5 bits, then a full frame
    r0 = rxc0;
    frame_begin(1'b0);
    xfer(1'b0, 8'hF0, 5, mi);
    frame_end(1'b0);
    check("abort_no_rx", 32'(rxc0 - r0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_oe", 32'(oe0), 32'd0);
    check("abort_miso", 32'(miso0), 32'd0);
    frame_begin(1'b0);
    xfer(1'b0, 8'h81, 8, mi);
    frame_end(1'b0);
    check("after_abort_rx", 32'(rx_last0), 32'h81);
    check("after_abort_pulses", 32'(rxc0 - r0), 32'd1);

    // Async reset mid-word
    push(1'b0, 8'h96);
    frame_begin(1'b0);
    push(1'b0, 8'h5C);
    xfer(1'b0, 8'hA0, 3, mi);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_outputs", 32'({miso0, oe0, rx_data0, rx_valid0, ready0, und0, busy0}),
          32'(rst_exp));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r0 = rxc0;
    xfer(1'b0, 8'hFF, 5, mi);
    check("stale_frame_busy", 32'(busy0), 32'd0);
    check("stale_frame_oe", 32'(oe0), 32'd0);
    frame_end(1'b0);
    check("stale_frame_no_rx", 32'(rxc0 - r0), 32'd0);
    push(1'b0, 8'h3A);
    frame_begin(1'b0);
    xfer(1'b0, 8'h6E, 8, mi);
    frame_end(1'b0);
    check("post_reset_rx", 32'(rx_last0), 32'h6E);
    check("post_reset_miso", 32'(mi), 32'h3A);

    // CPOL=1, CPHA=1
    @(negedge clk);
    sck = 1'b1;
    half();
    push(1'b1, 8'h5A);
    u3 = undc3;
    frame_begin(1'b1);
    xfer(1'b1, 8'hC3, 8, mi);
    frame_end(1'b1);
    check("m3_master_rx", 32'(mi), 32'h5A);
    check("m3_rx_data", 32'(rx_last3), 32'hC3);
    check("m3_rx_pulses", 32'(rxc3), 32'd1);
    check("m3_no_underrun", 32'(undc3 - u3), 32'd0);
    check("m3_ready_back", 32'(ready3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
